// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display path: digit codes, anode
// patterns, slot type, displayable range and the double-dabble nibble adjust.
package display_pkg;

    localparam logic [3:0] DIG_DASH  = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd11;

    localparam logic [3:0] AN_SLOT0 = 4'b1110;
    localparam logic [3:0] AN_SLOT1 = 4'b1101;
    localparam logic [3:0] AN_SLOT2 = 4'b1011;
    localparam logic [3:0] AN_SLOT3 = 4'b0111;

    typedef logic [1:0] slot_t;

    localparam int VAL_MAX = 9999;
    localparam int VAL_MIN = -999;

    // Add-3 correction applied to every BCD nibble of 5 or more before a shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic [3:0] slot_anode(input slot_t s);
        logic [3:0] a;
        case (s)
            2'd0:    a = AN_SLOT0;
            2'd1:    a = AN_SLOT1;
            2'd2:    a = AN_SLOT2;
            default: a = AN_SLOT3;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Load/status/output bundle between the calculator core and the display scanner.
interface display_scanner_if #(parameter int WIDTH = 14);
    logic             load;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic [3:0]       digit;
    logic [3:0]       enable;

    modport master (output load, value, input busy, digit, enable);
    modport slave  (input load, value, output busy, digit, enable);
endinterface

// File: rtl/display_scanner_bin2bcd_serial.sv
// Serial double-dabble converter: one shift per cycle, WIDTH iterations,
// single-cycle done pulse once the 16-bit BCD result is final.
module bin2bcd_serial
    import display_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] mag,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] bin_reg;
    logic [15:0]      bcd_reg;
    logic [CW-1:0]    iter_reg;
    logic             done_reg;
    logic [15:0]      bcd_adj;

    assign bcd_adj = bcd_adjust(bcd_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            iter_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        bin_reg   <= mag;
                        bcd_reg   <= '0;
                        iter_reg  <= '0;
                        state_reg <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_reg  <= {bcd_adj[14:0], bin_reg[WIDTH-1]};
                    bin_reg  <= bin_reg << 1;
                    iter_reg <= iter_reg + 1'b1;
                    if (iter_reg == ITER_LAST) begin
                        state_reg <= S_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == S_SHIFT);
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed display driver: capture, range check, formatting and
// slot scanning. Define LEADING_ZERO_BLANK_EN for blanking and a floating minus.
module display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int WIDTH       = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    display_scanner_if.slave  bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] RST_FILL = DIG_BLANK;
`else
    localparam logic [3:0] RST_FILL = 4'd0;
`endif

    logic signed [WIDTH-1:0] val;
    logic [WIDTH-1:0]        mag;
    int                      val_int;
    logic                    start, ovf_c, conv_busy, conv_done;
    logic [15:0]             bcd;
    logic                    neg_reg, ovf_reg;
    logic [3:0]              fmt       [4];
    logic [3:0]              disp_reg  [4];
    logic [3:0]              disp_next [4];
    logic [CW-1:0]           cnt_reg;
    slot_t                   slot_reg, slot_next;
    logic [3:0]              digit_reg, enable_reg;

    assign val   = bus.value;
    assign mag   = val[WIDTH-1] ? (~bus.value + WIDTH'(1)) : bus.value;
    assign start = bus.load & ~conv_busy;

    always_comb begin
        val_int = int'(val);
        ovf_c   = (val_int > VAL_MAX) || (val_int < VAL_MIN);
    end

    // Overflow values still run through the converter so every load has the same latency.
    bin2bcd_serial #(.WIDTH(WIDTH)) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mag   (mag),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

`ifdef LEADING_ZERO_BLANK_EN
    slot_t msd;
    always_comb begin
        msd = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (bcd[4*i +: 4] != 4'd0) msd = slot_t'(i);
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fmt
`ifdef LEADING_ZERO_BLANK_EN
            assign fmt[gi] = ovf_reg                             ? DIG_DASH :
                             (gi <= int'(msd))                   ? bcd[4*gi +: 4] :
                             (neg_reg && (gi == int'(msd) + 1))  ? DIG_DASH : DIG_BLANK;
`else
            if (gi == 3) begin : g_sign
                assign fmt[gi] = (ovf_reg || neg_reg) ? DIG_DASH : bcd[4*gi +: 4];
            end else begin : g_num
                assign fmt[gi] = ovf_reg ? DIG_DASH : bcd[4*gi +: 4];
            end
`endif
            assign disp_next[gi] = conv_done ? fmt[gi] : disp_reg[gi];
        end
    endgenerate

    assign slot_next = slot_reg + 2'd1;

    // A commit landing on a slot advance is shown on that advance via disp_next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
            cnt_reg    <= '0;
            slot_reg   <= 2'd0;
            digit_reg  <= 4'd0;
            enable_reg <= AN_SLOT0;
            for (int i = 0; i < 4; i++) begin
                disp_reg[i] <= (i == 0) ? 4'd0 : RST_FILL;
            end
        end else begin
            if (start) begin
                neg_reg <= val[WIDTH-1];
                ovf_reg <= ovf_c;
            end
            for (int i = 0; i < 4; i++) begin
                disp_reg[i] <= disp_next[i];
            end
            if (cnt_reg == CNT_LAST) begin
                cnt_reg    <= '0;
                slot_reg   <= slot_next;
                digit_reg  <= disp_next[slot_next];
                enable_reg <= slot_anode(slot_next);
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign bus.busy   = conv_busy;
    assign bus.digit  = digit_reg;
    assign bus.enable = enable_reg;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: stimulus queues expected slot outputs,
// a monitor pops and checks them on every slot advance.
module tb_display_scanner;
    localparam int WIDTH = 14;
    localparam int RDIV  = 4;

    typedef struct packed {
        logic [3:0] digit;
        logic [3:0] enable;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    display_scanner_if #(.WIDTH(WIDTH)) bus ();

    display_scanner #(.REFRESH_DIV(RDIV), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    bit   arm_req = 1'b0;
    int   armed = 0;
    logic [3:0] prev_en = 4'b1110;

    function automatic logic [3:0] anode(input int i);
        case (i)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // Reference display for a value: plain decimal arithmetic on the truncated input.
    function automatic logic [15:0] model(input int raw);
        logic signed [WIDTH-1:0] t;
        logic [15:0] r;
        int v, m, ndig;
        t = raw[WIDTH-1:0];
        v = int'(t);
        if (v > 9999 || v < -999) return {4{4'd10}};
        m = (v < 0) ? -v : v;
        ndig = (m >= 1000) ? 4 : (m >= 100) ? 3 : (m >= 10) ? 2 : 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = ndig; i < 4; i++) r[4*i +: 4] = 4'd11;
        if (v < 0) r[4*ndig +: 4] = 4'd10;
`else
        if (v < 0) r[15:12] = 4'd10;
`endif
        return r;
    endfunction

    // Monitor: each enable change is one slot presentation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.enable !== prev_en) begin
            prev_en = bus.enable;
            if (arm_req && bus.enable == 4'b1110) begin
                armed   = 4;
                arm_req = 1'b0;
            end
            if (armed > 0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_empty: got digit=%0d enable=%b, required a queued entry", bus.digit, bus.enable);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.digit !== e.digit || bus.enable !== e.enable) begin
                        fails++;
                        $display("FAIL slot_output: got digit=%0d enable=%b, required digit=%0d enable=%b",
                                 bus.digit, bus.enable, e.digit, e.enable);
                    end else begin
                        $display("[TB] slot enable=%b digit=%0d ok", bus.enable, bus.digit);
                    end
                end
                armed--;
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic expect_display(input int v);
        logic [15:0] d;
        d = model(v);
        for (int i = 0; i < 4; i++) exp_q.push_back('{digit: d[4*i +: 4], enable: anode(i)});
        arm_req = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!arm_req && armed == 0) break;
        end
        if (arm_req || armed != 0) begin
            tests++;
            fails++;
            $display("FAIL display_timeout: got %0d entries unchecked, required 0", exp_q.size());
            exp_q.delete();
            arm_req = 1'b0;
            armed   = 0;
        end
    endtask

    task automatic do_load(input int v, input int inject_at);
        int n;
        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = v[WIDTH-1:0];
        @(negedge clk);
        bus.load = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.busy) n++;
            else break;
            if (n == inject_at) begin
                bus.load  = 1'b1;
                bus.value = 14'd55;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        $display("[TB] load %0d busy for %0d cycles", v, n);
        check("busy_cycles", n, WIDTH);
        @(posedge clk);
        #1;
        expect_display(v);
    endtask

    initial begin
        int dir_vals[8] = '{1234, 7, -45, -999, 10000, -1000, 0, 9999};
        int rv;
        bus.load  = 1'b0;
        bus.value = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_enable", int'(bus.enable), 4'b1110);
        check("reset_digit", int'(bus.digit), 0);
        rst_n = 1'b1;
        expect_display(0);

        foreach (dir_vals[i]) do_load(dir_vals[i], -1);
        for (int i = 0; i < 10; i++) begin
            rv = int'($urandom_range(11700)) - 1200;
            do_load(rv, -1);
        end

        do_load(1234, 5);

        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = 14'd4321;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", int'(bus.busy), 0);
        check("midreset_enable", int'(bus.enable), 4'b1110);
        check("midreset_digit", int'(bus.digit), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("postreset_busy", int'(bus.busy), 0);
        expect_display(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
